vec_store_unit: RTL and testbench
=================================

# vec_store_unit

Vector store unit: the read-side counterpart of the vector register file. On a start command it reads a 1-, 4- or 16-word vector from the register file, snapshots it, and streams it word by word to data memory over a valid/ready write port. It sits between the vector issue stage and the data-memory arbiter.

## Interface
Parameters:
- ADDR_W, 32, memory byte-address width
- WORD_W, 32, element width (fixed by register file; not overridable in practice)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe, accepted only when busy=0
- vl  in  2  vector length code: 00=1 word, 01=4, 10=16, 11=illegal
- vs  in  5  source register base index
- base_addr  in  ADDR_W  byte address of element 0
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = illegal vl
- rf_ra  out  5  register-file read base index
- rf_rd  in  512  register-file read data (16 words, word j = reg rf_ra+j mod 32, combinational)
- mem_valid  out  1  write request valid
- mem_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  32  write data

## Operation
- FSM states: IDLE, READ, SEND, DONE.
- IDLE: busy=0. On start=1, latch vl, vs, base_addr; go READ (vl≠11) or DONE with err pending (vl=11).
- READ: rf_ra=latched vs; capture rf_rd into 512-bit snapshot; idx=0; go SEND.
- SEND: mem_valid=1, mem_wdata=snapshot word idx, mem_addr=base+4·idx (mod 2^ADDR_W). On mem_valid&mem_ready: if idx=N−1 go DONE, else idx++. N = 1/4/16 per vl.
- DONE: done=1, err=latched illegal flag; next cycle IDLE.
- Register index wrap: vs+j taken mod 32 by the register file; snapshot word j is therefore reg (vs+j) mod 32.
- Snapshot isolates the stream from register-file writes after READ; writes during SEND are not reflected.
- start while busy=1 is ignored (no queueing). start in the DONE cycle is ignored.
- rf_ra is held at latched vs in all states after the first command (0 after reset).

## Timing
- Reset values: busy=0, done=0, err=0, mem_valid=0, mem_addr=0, mem_wdata=0, rf_ra=0, state IDLE.
- busy=1 from the cycle after start acceptance through the DONE cycle.
- Zero-wait memory: start at cycle 0 → READ cycle 1 → first mem_valid cycle 2 → N words on cycles 2..N+1 → done cycle N+2.
- Illegal vl: done+err at cycle 1, no mem_valid ever.
- mem_valid, mem_addr, mem_wdata held stable while mem_valid=1 and mem_ready=0 (AXI-style rule); mem_valid never deasserts without a handshake.
- Reset mid-transfer: immediate abort, outputs to reset values, no done pulse.

## Configuration
- VSU_STRIDE_EN defined: extra input stride (ADDR_W, byte stride, latched at start); mem_addr=base+stride·idx, wrap mod 2^ADDR_W, stride 0 legal (all words to one address).
- Not defined: no stride port; unit stride of 4 bytes.

## Structure
- Package vsu_pkg: state enum, VL code constants (VL_1, VL_4, VL_16, VL_ILL), function vl_to_count returning 1/4/16/0.
- One sub-module vsu_addr_gen: holds base/stride, produces mem_addr from idx; contains the VSU_STRIDE_EN variation.

## Test plan
- vl=00, vs=3, reg3=0xDEADBEEF, base=0x100, ready=1 → one write {0x100, 0xDEADBEEF}, done at cycle 3, err=0.
- vl=01, vs=30, regs 30,31,0,1 = 1,2,3,4, base=0x200 → writes 0x200/1, 0x204/2, 0x208/3, 0x20C/4 (index wrap).
- vl=10, base=0x1000, mem_ready toggled 1,0,0,1,… → 16 writes in order, addr/data stable during stalls, done after 16th handshake.
- vl=11 → done=1, err=1 at cycle 1, mem_valid never asserted; second start during busy ignored.
- rst asserted mid vl=10 transfer after word 5 → outputs zero immediately, no done; new start runs cleanly from word 0.
- VSU_STRIDE_EN, stride=0x40, vl=01, base=0xFFFFFFC0 → addrs 0xFFFFFFC0, 0x0, 0x40, 0x80.

Source files
------------

// File: rtl/vsu_pkg.sv
// vsu_pkg: shared types, vector-length codes and helpers for the vector store unit
package vsu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;
  localparam logic [1:0] VL_1   = 2'b00;
  localparam logic [1:0] VL_4   = 2'b01;
  localparam logic [1:0] VL_16  = 2'b10;
  localparam logic [1:0] VL_ILL = 2'b11;
  function automatic logic [4:0] vl_to_count(input logic [1:0] vl);
    return vl == VL_1 ? 5'd1 : vl == VL_4 ? 5'd4 : vl == VL_16 ? 5'd16 : 5'd0;
  endfunction
endpackage

// File: rtl/vsu_addr_gen.sv
// vsu_addr_gen: holds base (and stride when VSU_STRIDE_EN is defined) and forms mem_addr from the word index
module vsu_addr_gen
  import vsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_in,
`ifdef VSU_STRIDE_EN
  input  logic [ADDR_W-1:0] stride_in,
`endif
  input  logic [3:0]        idx,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] base_q, base_d, step;
`ifdef VSU_STRIDE_EN
  logic [ADDR_W-1:0] stride_q, stride_d;
  // capture base and stride together when a command is accepted
  always_comb begin
    base_d   = load ? base_in : base_q;
    stride_d = load ? stride_in : stride_q;
  end
  // base/stride registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      base_q   <= '0;
      stride_q <= '0;
    end else begin
      base_q   <= base_d;
      stride_q <= stride_d;
    end
  assign step = stride_q;
`else
  // capture base when a command is accepted
  always_comb base_d = load ? base_in : base_q;
  // base register
  always_ff @(posedge clk or posedge rst)
    if (rst) base_q <= '0;
    else base_q <= base_d;
  assign step = ADDR_W'(4);
`endif
  assign addr = base_q + step * ADDR_W'(idx);
endmodule

// File: rtl/vec_store_unit.sv
// vec_store_unit: snapshot a 1/4/16-word vector from the register file and stream it to memory (VSU_STRIDE_EN adds a stride port)
module vec_store_unit
  import vsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           vl,
  input  logic [4:0]           vs,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [4:0]           rf_ra,
  input  logic [16*WORD_W-1:0] rf_rd,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WORD_W-1:0]    mem_wdata
`ifdef VSU_STRIDE_EN
  ,
  input  logic [ADDR_W-1:0]    stride
`endif
);
  state_t              state_q, state_d;
  logic [4:0]          vs_q, vs_d, cnt_q, cnt_d;
  logic [3:0]          idx_q, idx_d;
  logic                err_q, err_d, load;
  logic [16*WORD_W-1:0] snap_q, snap_d;
  logic [ADDR_W-1:0]   gen_addr;
  // command sequencing: accept, snapshot, stream until last handshake, pulse done
  always_comb begin
    state_d = state_q;
    vs_d    = vs_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    snap_d  = snap_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        load    = 1'b1;
        vs_d    = vs;
        cnt_d   = vl_to_count(vl);
        err_d   = vl == VL_ILL;
        state_d = vl == VL_ILL ? S_DONE : S_READ;
      end
      S_READ: begin
        snap_d  = rf_rd;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: if (mem_ready) begin
        state_d = {1'b0, idx_q} == cnt_q - 5'd1 ? S_DONE : S_SEND;
        idx_d   = {1'b0, idx_q} == cnt_q - 5'd1 ? idx_q : idx_q + 4'd1;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      vs_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      snap_q  <= snap_d;
    end
  vsu_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .base_in  (base_addr),
`ifdef VSU_STRIDE_EN
    .stride_in(stride),
`endif
    .idx      (idx_q),
    .addr     (gen_addr)
  );
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign err       = done & err_q;
  assign rf_ra     = vs_q;
  assign mem_valid = state_q == S_SEND;
  assign mem_addr  = mem_valid ? gen_addr : '0;
  assign mem_wdata = mem_valid ? snap_q[idx_q*WORD_W +: WORD_W] : '0;
endmodule

// File: tb/tb_vec_store_unit.sv
// tb_vec_store_unit: directed self-checking bench for vec_store_unit
module tb_vec_store_unit;
  logic         clk = 0, rst = 1, start = 0, mem_ready = 0;
  logic [1:0]   vl = 0;
  logic [4:0]   vs = 0, rf_ra;
  logic [31:0]  base_addr = 0, mem_addr, mem_wdata;
  logic [511:0] rf_rd;
  logic         busy, done, err, mem_valid;
  logic [31:0]  rf [32];
  int           vectors = 0, miscompares = 0;
`ifdef VSU_STRIDE_EN
  logic [31:0]  stride = 0;
`endif

  vec_store_unit dut (
    .clk(clk), .rst(rst), .start(start), .vl(vl), .vs(vs), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err), .rf_ra(rf_ra), .rf_rd(rf_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
`ifdef VSU_STRIDE_EN
    , .stride(stride)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    rf_rd = '0;
    for (int j = 0; j < 16; j++) rf_rd[j*32 +: 32] = rf[5'(rf_ra + 5'(j))];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] v, input logic [4:0] s, input logic [31:0] b);
    vl = v; vs = s; base_addr = b; start = 1;
    tick();
    start = 0;
  endtask

  // expects to be entered on the first SEND cycle; checks every cycle until n handshakes, then done
  task automatic stream(input int n, input logic [4:0] s, input logic [31:0] b, input logic [31:0] st, input bit toggle);
    logic [31:0] exp_rf [32];
    int w = 0, cyc = 0;
    bit r;
    exp_rf = rf;
    while (w < n && cyc < 200) begin
      r = toggle ? (cyc % 3 == 0) : 1'b1;
      mem_ready = r;
      if (toggle && cyc == 4) rf[s] = ~rf[s];
      chk("mem_valid", 64'(mem_valid), 64'(1));
      chk("mem_addr", 64'(mem_addr), 64'(b + st * w));
      chk("mem_wdata", 64'(mem_wdata), 64'(exp_rf[5'(s + 5'(w))]));
      tick();
      if (r) w++;
      cyc++;
    end
    mem_ready = 0;
    chk("stream_words", 64'(w), 64'(n));
    chk("done", 64'(done), 64'(1));
    chk("err", 64'(err), 64'(0));
    chk("valid_in_done", 64'(mem_valid), 64'(0));
    tick();
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_done", 64'(done), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 + i;
    rf[3] = 32'hDEAD_BEEF;
    rf[30] = 1; rf[31] = 2; rf[0] = 3; rf[1] = 4;
    #2;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_valid", 64'(mem_valid), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_wdata", 64'(mem_wdata), 0);
    chk("rst_ra", 64'(rf_ra), 0);
    tick();
    rst = 0;
    tick();
    // single word
    cmd(2'b00, 5'd3, 32'h100);
    chk("t1_read_busy", 64'(busy), 1);
    chk("t1_read_valid", 64'(mem_valid), 0);
    chk("t1_ra", 64'(rf_ra), 3);
    tick();
    stream(1, 5'd3, 32'h100, 4, 0);
    // sixteen words with stalls, snapshot isolation, start during busy ignored
    cmd(2'b10, 5'd0, 32'h1000);
    start = 1; vs = 5'd7;
    tick();
    start = 0;
    chk("t3_ra_hold", 64'(rf_ra), 0);
    stream(16, 5'd0, 32'h1000, 4, 1);
    chk("t3_ra_after", 64'(rf_ra), 0);
    // illegal length: done+err at cycle 1, start in DONE cycle ignored
    cmd(2'b11, 5'd9, 32'h300);
    chk("t4_done", 64'(done), 1);
    chk("t4_err", 64'(err), 1);
    chk("t4_busy", 64'(busy), 1);
    chk("t4_valid", 64'(mem_valid), 0);
    start = 1; vl = 2'b00;
    tick();
    start = 0;
    chk("t4_start_in_done", 64'(busy), 0);
    chk("t4_done_clear", 64'(done), 0);
    tick();
    chk("t4_still_idle", 64'(busy), 0);
    chk("t4_no_valid", 64'(mem_valid), 0);
    // reset during a sixteen-word transfer
    cmd(2'b10, 5'd0, 32'h2000);
    tick();
    mem_ready = 1;
    repeat (5) tick();
    chk("t5_word5_addr", 64'(mem_addr), 64'(32'h2014));
    rst = 1;
    #1;
    chk("t5_busy", 64'(busy), 0);
    chk("t5_valid", 64'(mem_valid), 0);
    chk("t5_addr", 64'(mem_addr), 0);
    chk("t5_wdata", 64'(mem_wdata), 0);
    chk("t5_ra", 64'(rf_ra), 0);
    chk("t5_done", 64'(done), 0);
    mem_ready = 0;
    tick();
    rst = 0;
    tick();
    chk("t5_no_done", 64'(done), 0);
    // four words with register index wrap, after the abort
    cmd(2'b01, 5'd30, 32'h200);
    chk("t2_ra", 64'(rf_ra), 30);
    tick();
    stream(4, 5'd30, 32'h200, 4, 0);
`ifdef VSU_STRIDE_EN
    stride = 32'h40;
    cmd(2'b01, 5'd30, 32'hFFFF_FFC0);
    tick();
    stream(4, 5'd30, 32'hFFFF_FFC0, 32'h40, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
